// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands each grant winner a fresh byte from a shared
// 8-bit Fibonacci LFSR (taps 7,5,4,3), with runtime reseed and optional free-run.
module lfsr_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter logic [7:0]  SEED    = 8'hFF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [7:0]         rand_o,
  output logic               rand_vld_o,
  input  logic [7:0]         seed_i,
  input  logic               seed_load_i,
  input  logic               free_run_i,
  output logic               busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           rand_q, rand_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        cand;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Scan upward from the last winner + 1 so the previous winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Transitions are identical from every state; seed loads beat requests.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rand_d  = rand_q;
    vld_d   = 1'b0;
    busy_d  = 1'b0;

    if (seed_load_i)    state_d = LOAD;
    else if (win_found) state_d = GRANT;
    else                state_d = IDLE;

    unique case (state_d)
      LOAD: begin
        lfsr_d = (seed_i == 8'h00) ? SEED : seed_i;
        busy_d = 1'b1;
      end
      GRANT: begin
        gnt_d  = NUM_REQ'(1) << win_idx;
        vld_d  = 1'b1;
        rand_d = lfsr_q;
        lfsr_d = lfsr_step(lfsr_q);
        ptr_d  = win_idx;
      end
      default: begin
        if (free_run_i) lfsr_d = lfsr_step(lfsr_q);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      ptr_q   <= PW'(NUM_REQ - 1);
      gnt_q   <= '0;
      rand_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rand_q  <= rand_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign rand_o     = rand_q;
  assign rand_vld_o = vld_q;
  assign busy_o     = busy_q;

endmodule
